// File: rtl/de0qsys_led_pio.sv
// de0qsys_led_pio: Avalon-MM output PIO that drives the DE0 LEDs.
// It has a data register, atomic bit set/clear, and a per-bit hardware blink
// driven by a shared prescaled timebase. Slave timing is zero-wait-state writes
// and one-cycle read latency.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    register select (0 DATA, 1 BLINK_MASK, 2 HALF, 3 CTRL,
//              4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data, for the address sampled on the previous edge
//   out_port   registered LED drive
module de0qsys_led_pio #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned DEFAULT_HALF = 250
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

    localparam logic [2:0] AddrData     = 3'd0;
    localparam logic [2:0] AddrMask     = 3'd1;
    localparam logic [2:0] AddrHalf     = 3'd2;
    localparam logic [2:0] AddrCtrl     = 3'd3;
    localparam logic [2:0] AddrOutSet   = 3'd4;
    localparam logic [2:0] AddrOutClear = 3'd5;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [15:0]      half_q, half_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [15:0]      hcnt_q, hcnt_d;
    logic             phase_q, phase_d;
    logic [31:0]      rdata_d;
    logic [WIDTH-1:0] out_d;

    logic             wr;
    logic             tick;
    logic [WIDTH-1:0] wd;

    // Only the low WIDTH (or 16) bits of writedata matter.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr   = chipselect && !write_n;
    assign tick = (pre_q == PreMax);
    assign wd   = writedata[WIDTH-1:0];

    always_comb begin
        data_d  = data_q;
        mask_d  = mask_q;
        half_d  = half_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;

        // Timebase: HALF==0 parks the blink in the on phase.
        if (half_q == 16'd0) begin
            hcnt_d  = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (hcnt_q == half_q - 16'd1) begin
                hcnt_d  = '0;
                phase_d = !phase_q;
            end else begin
                hcnt_d = hcnt_q + 16'd1;
            end
        end

        // Register writes override any timebase activity in the same cycle.
        if (wr) begin
            case (address)
                AddrData:     data_d = wd;
                AddrMask:     mask_d = wd;
                AddrHalf: begin
                    half_d  = writedata[15:0];
                    pre_d   = '0;
                    hcnt_d  = '0;
                    phase_d = phase_q;
                end
                AddrCtrl: begin
                    pre_d   = '0;
                    hcnt_d  = '0;
                    phase_d = 1'b0;
                end
                AddrOutSet:   data_d = data_q | wd;
                AddrOutClear: data_d = data_q & ~wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            AddrData: rdata_d = 32'(data_q);
            AddrMask: rdata_d = 32'(mask_q);
            AddrHalf: rdata_d = 32'(half_q);
            AddrCtrl: rdata_d = {31'd0, phase_q};
            default:  rdata_d = '0;
        endcase
    end

    // Blinking bits are forced off while phase is 1.
    assign out_d = data_q & ~(mask_q & {WIDTH{phase_q}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            mask_q   <= '0;
            half_q   <= 16'(DEFAULT_HALF);
            pre_q    <= '0;
            hcnt_q   <= '0;
            phase_q  <= 1'b0;
            readdata <= '0;
            out_port <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            half_q   <= half_d;
            pre_q    <= pre_d;
            hcnt_q   <= hcnt_d;
            phase_q  <= phase_d;
            readdata <= rdata_d;
            out_port <= out_d;
        end
    end

endmodule

// File: tb/tb_de0qsys_led_pio.sv
module tb_de0qsys_led_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int total = 0;
    int bad = 0;
    logic [31:0] v;

    de0qsys_led_pio #(
        .WIDTH(8),
        .PRESCALE(4),
        .DEFAULT_HALF(250)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = !clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        step();
        d = readdata;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset, release between edges.
        #22;
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_rdata", readdata, 32'h0);
        reset_n = 1'b1;
        #1;
        rd(3'd0, v); check("rst_data", v, 32'd0);
        rd(3'd1, v); check("rst_mask", v, 32'd0);
        rd(3'd2, v); check("rst_half", v, 32'd250);
        rd(3'd3, v); check("rst_ctrl", v, 32'd0);
        check("rst_out2", 32'(out_port), 32'h0);

        // Data, set, clear; out_port one clk after each write.
        wr(3'd0, 32'h1234_56A5); step(); check("out_data", 32'(out_port), 32'hA5);
        wr(3'd4, 32'hFFFF_FF0F); step(); check("out_set", 32'(out_port), 32'hAF);
        wr(3'd5, 32'h0000_0081); step(); check("out_clr", 32'(out_port), 32'h2E);
        rd(3'd0, v); check("rd_data", v, 32'h2E);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, v); check("rd_rsv6", v, 32'h0);
        rd(3'd4, v); check("rd_outset", v, 32'h0);
        rd(3'd0, v); check("rsv_nowr", v, 32'h2E);

        // Blink: HALF=3, PRESCALE=4 -> phase toggles every 12 clks after CTRL write.
        wr(3'd1, 32'h0000_000F);
        wr(3'd0, 32'h0000_00FF);
        wr(3'd2, 32'hABCD_0003);
        rd(3'd2, v); check("rd_half", v, 32'd3);
        wr(3'd3, 32'h0);                    // edge C
        steps(11); check("blk_c11", 32'(out_port), 32'hFF);
        step();    check("blk_c12", 32'(out_port), 32'hFF);
        step();    check("blk_c13", 32'(out_port), 32'hF0);
        address = 3'd3;
        step();    check("ctrl_ph1", readdata, 32'd1);
        steps(10); check("blk_c24", 32'(out_port), 32'hF0);
        step();    check("blk_c25", 32'(out_port), 32'hFF);
        check("ctrl_ph0", readdata, 32'd0);

        // HALF=0 while phase=1 stops blinking.
        steps(11);                          // C+36: phase just became 1
        step();    check("blk_c37", 32'(out_port), 32'hF0);
        wr(3'd2, 32'h0);                    // C+38
        step();    check("h0_c39", 32'(out_port), 32'hF0);
        step();    check("h0_c40", 32'(out_port), 32'hFF);
        address = 3'd3;
        step();    check("h0_phase", readdata, 32'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            check("h0_steady", 32'(out_port), 32'hFF);
        end

        // CTRL write on the cycle a toggle is due cancels it.
        wr(3'd2, 32'd3);                    // edge H
        steps(11);
        wr(3'd3, 32'h0);                    // H+12, toggle due here
        address = 3'd3;
        step();    check("ctl_noph", readdata, 32'd0);
        check("ctl_h13", 32'(out_port), 32'hFF);
        steps(11); check("ctl_h24", 32'(out_port), 32'hFF);
        step();    check("ctl_h25", 32'(out_port), 32'hF0);
        check("ctl_ph1", readdata, 32'd1);

        // Asynchronous reset mid-blink.
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out", 32'(out_port), 32'h0);
        check("arst_rdata", readdata, 32'h0);
        #2;
        reset_n = 1'b1;
        #1;
        rd(3'd2, v); check("arst_half", v, 32'd250);
        rd(3'd1, v); check("arst_mask", v, 32'd0);
        rd(3'd0, v); check("arst_data", v, 32'd0);
        steps(20); check("arst_out2", 32'(out_port), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/de0qsys_led_pio.md
Name: de0qsys_led_pio

Overview:
- Avalon-MM output PIO. It is the write-side counterpart of the board's button input PIO: the CPU writes registers here and the block drives the DE0 LEDs.
- Provides a data register, atomic bit set and bit clear, and hardware blink per bit from a shared prescaled timebase, so software never has to toggle LEDs itself.
- Sits on the Qsys system interconnect next to the button PIO, with the same one-clock, zero-wait-state slave timing.

Parameters:
- WIDTH, 8, number of output bits driven on out_port (1..32).
- PRESCALE, 50000, clk cycles per timebase tick (1 ms at 50 MHz); must be >= 1.
- DEFAULT_HALF, 250, reset value of the blink half-period register, in ticks.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. Asynchronous, active-low.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Register map:
  - 0 DATA: R/W, WIDTH bits.
  - 1 BLINK_MASK: R/W, WIDTH bits.
  - 2 HALF: R/W, 16 bits.
  - 3 CTRL: read bit0 = phase; write of any value resyncs the blink timebase.
  - 4 OUTSET: W, DATA |= writedata[WIDTH-1:0].
  - 5 OUTCLEAR: W, DATA &= ~writedata[WIDTH-1:0].
  - 6, 7: reserved; writes ignored, reads 0.
- Write strobe: chipselect && !write_n. Registers update on the strobe edge, with no wait states.
- Read path:
  - readdata is registered every clk regardless of chipselect.
  - It holds the zero-extended register selected by the address sampled on the previous edge (one-cycle read latency).
  - Addresses 4..7 read 0.
- Reset values: readdata=0, out_port=0, DATA=0, BLINK_MASK=0, HALF=DEFAULT_HALF, phase=0, both counters=0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted for the one cycle in which pre_cnt==PRESCALE-1.
- Half-period counter:
  - When HALF!=0: on tick, if hcnt==HALF-1 then hcnt<=0 and phase toggles; otherwise hcnt increments.
  - Result: phase toggles every HALF*PRESCALE clk cycles.
  - When HALF==0: hcnt and phase are held at 0 and blinking stops.
- Write to HALF: loads the new value and clears pre_cnt and hcnt in the same edge; phase is unchanged.
- Write to CTRL: clears pre_cnt, hcnt and phase in the same edge.
- Output:
  - out_port <= DATA & ~(BLINK_MASK & {WIDTH{phase}}), registered.
  - A bit blinks only if both its DATA bit and its BLINK_MASK bit are 1. In the off phase it is forced 0.
  - out_port reflects a register or phase change one clk after that change.
- Simultaneous events:
  - A DATA/OUTSET/OUTCLEAR write in the same cycle as a phase toggle: both take effect, and out_port uses the new DATA with the new phase one cycle later.
  - A CTRL or HALF write on a cycle where a toggle would occur: the write wins and no toggle happens.
- writedata bits above WIDTH (above 16 for HALF) are ignored.
- Reset asserted mid-operation forces all state to its reset values immediately, without waiting for clk. Blinking resumes from phase=0 after release.

Test Plan:
- Reset, then read addresses 0..3 -> readdata 0, 0, 250, 0 on the cycle after each address; out_port=0.
- Write DATA=0xA5, write OUTSET=0x0F, write OUTCLEAR=0x81 -> DATA reads 0x2E; out_port equals 0xA5, 0xAF, 0x2E, each one clk after its write.
- PRESCALE=4, HALF=3, DATA=0xFF, BLINK_MASK=0x0F, then CTRL write -> phase toggles every 12 clks; out_port alternates 0xFF / 0xF0, and CTRL reads phase.
- HALF=0 while blinking with phase=1 -> phase forced 0 next edge; out_port=DATA steady and no further toggles over 100 clks.
- CTRL write in the same cycle a toggle is due -> no toggle; phase=0; next toggle occurs a full HALF*PRESCALE later.
- reset_n low mid-blink, between clock edges -> out_port=0 and readdata=0 immediately; after release HALF reads 250 and blinking is stopped because BLINK_MASK=0.
